// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_responder
//  Purpose  : Data-memory responder with a fixed programmable latency. It
//             services one load/store at a time and returns a one-cycle
//             response. The optional macro DATA_MEMORY_RESPONDER_BYTE_ENABLE_EN
//             enables per-lane store masking.
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2     // legal range 1..15
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  input  logic [3:0]  reqByteEnable,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic        busy
);

  localparam int          c_ADDR_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_WAIT       = 2'd1;
  localparam logic [1:0]  c_RESP       = 2'd2;
  localparam logic [3:0]  c_COUNT_LOAD = 4'(LATENCY - 1);
  localparam logic [29:0] c_DEPTH      = 30'(DEPTH_WORDS);

  logic [1:0]          r_state;
  logic [1:0]          w_nextState;
  logic [3:0]          r_count;
  logic                r_write;
  logic [31:0]         r_address;
  logic [31:0]         r_writeData;
  logic [3:0]          r_byteEnable;
  logic [31:0]         r_respData;
  logic                r_respError;
  logic [31:0]         r_mem [DEPTH_WORDS];
  logic                w_accept;
  logic                w_commit;
  logic                w_error;
  logic [c_ADDR_W-1:0] w_index;
  logic [31:0]         w_laneMask;

  assign w_accept = (r_state == c_IDLE) && reqValid;
  // Array access happens on the edge that moves WAIT -> RESP.
  assign w_commit = (r_state == c_WAIT) && (r_count == 4'd0);
  assign w_error  = (r_address[31:2] >= c_DEPTH) || (r_address[1:0] != 2'b00);
  assign w_index  = r_address[c_ADDR_W+1:2];

`ifdef DATA_MEMORY_RESPONDER_BYTE_ENABLE_EN
  for (genvar g = 0; g < 4; g++) begin : g_laneMask
    assign w_laneMask[8*g +: 8] = {8{r_byteEnable[g]}};
  end
`else
  logic w_unusedByteEnable;
  assign w_unusedByteEnable = ^r_byteEnable;
  assign w_laneMask         = 32'hFFFF_FFFF;
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (reqValid) w_nextState = c_WAIT;
      c_WAIT:  if (r_count == 4'd0) w_nextState = c_RESP;
      c_RESP:  w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    reqReady  = 1'b0;
    respValid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      c_IDLE: begin
        reqReady = 1'b1;
        busy     = 1'b0;
      end
      c_RESP:  respValid = 1'b1;
      default: ;
    endcase
  end

  assign respData  = r_respData;
  assign respError = r_respError;

  // Request latch, latency counter and registered response
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count      <= 4'd0;
      r_write      <= 1'b0;
      r_address    <= 32'd0;
      r_writeData  <= 32'd0;
      r_byteEnable <= 4'd0;
      r_respData   <= 32'd0;
      r_respError  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count      <= c_COUNT_LOAD;
        r_write      <= reqWrite;
        r_address    <= reqAddress;
        r_writeData  <= reqWriteData;
        r_byteEnable <= reqByteEnable;
      end else if ((r_state == c_WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end

      if (w_commit) begin
        r_respError <= w_error;
        r_respData  <= (w_error || r_write) ? 32'd0 : r_mem[w_index];
      end else if (r_state == c_RESP) begin
        r_respError <= 1'b0;
        r_respData  <= 32'd0;
      end
    end
  end

  // Storage array is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (w_commit && r_write && !w_error) begin
      r_mem[w_index] <= (r_mem[w_index] & ~w_laneMask) | (r_writeData & w_laneMask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// Testbench for data_memory_responder: directed stimulus with a response
// scoreboard, LATENCY=2 and DEPTH_WORDS=256.
module tb_data_memory_responder;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddress = 32'd0;
  logic [31:0] reqWriteData = 32'd0;
  logic [3:0]  reqByteEnable = 4'd0;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   failures = 0;
  logic [31:0] expByteEnable;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(LATENCY)) dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData),
    .reqByteEnable(reqByteEnable),
    .respValid(respValid), .respData(respData), .respError(respError),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (respValid === 1'b1) begin
      if (sbQ.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        check({e.tag, "_data"}, respData, e.data);
        check({e.tag, "_err"}, {31'd0, respError}, {31'd0, e.err});
      end
    end
  end

  task automatic doReq(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] expD,
                       input bit expE, input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (reqReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1; reqWrite = w; reqAddress = a; reqWriteData = d; reqByteEnable = be;
    sbQ.push_back('{expD, expE, tag});
    @(posedge clk); #1;
    reqValid = 1'b0;
    n = 0;
    while (respValid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, LATENCY);
  endtask

  initial begin
`ifdef DATA_MEMORY_RESPONDER_BYTE_ENABLE_EN
    expByteEnable = 32'h1122CC44;
`else
    expByteEnable = 32'hAABBCCDD;
`endif
    #3;
    check("rst_ready", {31'd0, reqReady}, 32'd1);
    check("rst_valid", {31'd0, respValid}, 32'd0);
    check("rst_data", respData, 32'd0);
    check("rst_err", {31'd0, respError}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    doReq(1'b1, 32'h10, 32'h11223344, 4'hF, 32'd0, 1'b0, "st10");
    doReq(1'b0, 32'h10, 32'd0, 4'h0, 32'h11223344, 1'b0, "ld10");
    doReq(1'b1, 32'h10, 32'hAABBCCDD, 4'b0010, 32'd0, 1'b0, "st10_be");
    doReq(1'b0, 32'h10, 32'd0, 4'h0, expByteEnable, 1'b0, "ld10_be");

    doReq(1'b0, 32'h400, 32'd0, 4'h0, 32'd0, 1'b1, "ld400_err");
    doReq(1'b1, 32'h12, 32'h55555555, 4'hF, 32'd0, 1'b1, "st12_err");
    doReq(1'b0, 32'h10, 32'd0, 4'h0, expByteEnable, 1'b0, "ld10_after_err");
    doReq(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, "st3fc");
    doReq(1'b0, 32'h3FC, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0, "ld3fc");
    doReq(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 32'd0, 1'b0, "st20");

    // Second request held through WAIT/RESP must wait for IDLE.
    @(negedge clk);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 32'h10; reqByteEnable = 4'h0;
    sbQ.push_back('{expByteEnable, 1'b0, "busy_ld10"});
    @(posedge clk); #1;
    reqWrite = 1'b1; reqAddress = 32'h30; reqWriteData = 32'h5A5A5A5A; reqByteEnable = 4'hF;
    sbQ.push_back('{32'd0, 1'b0, "busy_st30"});
    check("busy_wait", {31'd0, busy}, 32'd1);
    check("busy_ready_wait", {31'd0, reqReady}, 32'd0);
    @(posedge clk); #1;
    check("busy_ready_wait2", {31'd0, reqReady}, 32'd0);
    @(posedge clk); #1;
    check("busy_resp", {31'd0, respValid}, 32'd1);
    check("busy_ready_resp", {31'd0, reqReady}, 32'd0);
    @(posedge clk); #1;
    check("busy_idle_ready", {31'd0, reqReady}, 32'd1);
    check("busy_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("busy_second_accepted", {31'd0, busy}, 32'd1);
    reqValid = 1'b0;
    repeat (4) @(posedge clk);
    doReq(1'b0, 32'h30, 32'd0, 4'h0, 32'h5A5A5A5A, 1'b0, "ld30");

    // Reset pulse during WAIT of a store: dropped, no response.
    @(negedge clk);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 32'h20; reqWriteData = 32'hDEADBEEF; reqByteEnable = 4'hF;
    @(posedge clk); #1;
    reqValid = 1'b0;
    check("inflight_busy", {31'd0, busy}, 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, reqReady}, 32'd1);
    check("async_rst_valid", {31'd0, respValid}, 32'd0);
    check("async_rst_data", respData, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dropped_no_resp", {31'd0, respValid}, 32'd0);
    end
    doReq(1'b0, 32'h20, 32'd0, 4'h0, 32'h0BADF00D, 1'b0, "ld20_after_rst");

    repeat (3) @(negedge clk);
    check("sb_empty", sbQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
